// File: rtl/pll_reset_sequencer.sv
// PLL-domain reset sequencer: lock sync, glitch filter, hold, run.
// Define PLL_RESET_SEQ_LOSS_COUNT_EN to add the loss_count port.
`timescale 1ns/1ps
module pll_reset_sequencer #(
    parameter int unsigned LOCK_FILTER = 16,
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       sys_reset,
    output logic       ready,
    output logic [1:0] state
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    ,
    output logic [7:0] loss_count
`endif
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sys_reset_q;
    logic             ready_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_lock;
            sync2_q <= sync1_q;
        end
    end

    // Terminal compare is checked before any increment so cnt never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (sync2_q) state_d = FILTER;
            end
            FILTER: begin
                if (!sync2_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == FILT_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!sync2_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!sync2_q) state_d = WAIT_LOCK;
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs register from next-state so they move with the RUN boundary.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sys_reset_q <= (state_d != RUN);
            ready_q     <= (state_d == RUN);
        end
    end

    assign state     = state_q;
    assign sys_reset = sys_reset_q;
    assign ready     = ready_q;

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    logic [7:0] loss_q;
    logic [7:0] loss_d;

    always_comb begin
        loss_d = loss_q;
        if (state_q == RUN && state_d == WAIT_LOCK && loss_q != 8'hFF)
            loss_d = loss_q + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) loss_q <= 8'd0;
        else       loss_q <= loss_d;
    end

    assign loss_count = loss_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer (LOCK_FILTER=4, HOLD_CYCLES=8).
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       sys_reset;
    logic       ready;
    logic [1:0] state;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    logic [7:0] loss_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    pll_reset_sequencer #(
        .LOCK_FILTER(4),
        .HOLD_CYCLES(8),
        .CNT_W(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .pll_lock(pll_lock),
        .sys_reset(sys_reset),
        .ready(ready),
        .state(state)
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
        ,
        .loss_count(loss_count)
`endif
    );

    typedef struct {
        logic       rst;
        logic       lock;
        int         edges;
        logic [1:0] st;
        logic       sr;
        logic       rdy;
        int         loss;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic r, logic l, int n, logic [1:0] s,
                                logic sr, logic rd, int lc);
        vec_t v;
        v.rst = r; v.lock = l; v.edges = n; v.st = s;
        v.sr = sr; v.rdy = rd; v.loss = lc;
        vecs.push_back(v);
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(string name, int idx, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        pll_lock = 1'b1;

        // reset held with lock high
        for (int i = 0; i < 5; i++) add(1, 1, 1, 0, 1, 0, 0);
        // release: FILTER at edge 3, HOLD at 7, RUN at 15
        add(0, 1, 2, 0, 1, 0, 0);
        add(0, 1, 1, 1, 1, 0, 0);
        add(0, 1, 4, 2, 1, 0, 0);
        add(0, 1, 7, 2, 1, 0, 0);
        add(0, 1, 1, 3, 0, 1, 0);
        // lock drop in RUN: reset back on 3rd edge
        add(0, 0, 2, 3, 0, 1, 0);
        add(0, 0, 1, 0, 1, 0, 1);
        // short lock: drop during FILTER, not counted
        add(0, 1, 3, 1, 1, 0, 1);
        add(0, 0, 2, 1, 1, 0, 1);
        add(0, 0, 1, 0, 1, 0, 1);
        // relock: full sequence
        add(0, 1, 14, 2, 1, 0, 1);
        add(0, 1, 1, 3, 0, 1, 1);
        // drop again, relock to HOLD cnt=5, then reset
        add(0, 0, 3, 0, 1, 0, 2);
        add(0, 1, 12, 2, 1, 0, 2);
        add(1, 1, 1, 0, 1, 0, 0);
        add(0, 1, 14, 2, 1, 0, 0);
        add(0, 1, 1, 3, 0, 1, 0);

        foreach (vecs[i]) begin
            reset    = vecs[i].rst;
            pll_lock = vecs[i].lock;
            step(vecs[i].edges);
            chk("state", i, int'(state), int'(vecs[i].st));
            chk("sys_reset", i, int'(sys_reset), int'(vecs[i].sr));
            chk("ready", i, int'(ready), int'(vecs[i].rdy));
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
            chk("loss_count", i, int'(loss_count), vecs[i].loss);
`endif
        end

        // repeated lock losses from RUN; counter saturates
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b0;
            step(3);
            chk("loss_state", i, int'(state), 0);
            chk("loss_sysrst", i, int'(sys_reset), 1);
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
            chk("loss_cnt", i, int'(loss_count), (i + 1 > 255) ? 255 : i + 1);
`endif
            pll_lock = 1'b1;
            step(15);
            chk("relock_ready", i, int'(ready), 1);
        end

        // lock never asserted
        reset    = 1'b1;
        pll_lock = 1'b0;
        step(1);
        reset = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            step(1);
            chk("nolock_state", i, int'(state), 0);
            chk("nolock_sysrst", i, int'(sys_reset), 1);
            chk("nolock_ready", i, int'(ready), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
